// File: rtl/weight_pkg.sv
// Shared definitions for the classifier weight memory: default geometry,
// sequencer states and the helpers that define the power-on weight pattern
// and the modulo-DEPTH burst address arithmetic.
package weight_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 30;
    localparam int DEFAULT_LANES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    // Default word for a row. Rows are grouped LANES at a time and the
    // groups cycle through three shapes: alternating bits whose phase follows
    // row parity, fixed 0101..., and an upper-half block of ones.
    function automatic logic [63:0] pattern(input int row, input int width, input int lanes);
        logic [63:0] word;
        int          group;
        word  = '0;
        group = (row / lanes) % 3;
        for (int b = 0; b < 64; b++) begin
            if (b < width) begin
                case (group)
                    0:       word[b] = (((width - 1 - b) % 2) == 0) ^ ((row % 2) != 0);
                    1:       word[b] = (((width - 1 - b) % 2) == 1);
                    default: word[b] = (b >= (width / 2));
                endcase
            end
        end
        return word;
    endfunction

    // Wrapping address add: base and offset are both below depth, so a
    // single conditional subtract replaces a modulo.
    function automatic int wrap_add(input int base, input int offset, input int depth);
        int sum;
        sum = base + offset;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/weight_init_seq.sv
// Init sequencer: owns the IDLE/INIT state and the row counter, and while
// in INIT emits one default-pattern row write per cycle.
module weight_init_seq
    import weight_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LANES  = DEFAULT_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] row,
    output logic [WIDTH-1:0]  data,
    output logic              wr_en
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] row_cnt;
    logic [ADDR_W-1:0] row_next;

    // State and row counter; reset lands in INIT so the pattern loads at power-up.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= INIT;
            row_cnt <= '0;
        end else begin
            state   <= state_next;
            row_cnt <= row_next;
        end
    end

    // Walk rows 0..DEPTH-1 in INIT, then park in IDLE until a start request.
    always_comb begin
        state_next = state;
        row_next   = row_cnt;
        case (state)
            INIT: begin
                if (row_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    row_next   = '0;
                end else begin
                    row_next = row_cnt + ADDR_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_next = INIT;
                    row_next   = '0;
                end
            end
        endcase
    end

    assign busy  = (state == INIT);
    assign wr_en = (state == INIT);
    assign row   = row_cnt;
    assign data  = WIDTH'(pattern(int'(row_cnt), WIDTH, LANES));

endmodule

// File: rtl/weight_bank.sv
// Multi-lane weight memory: LANES-word read/write bursts with wrapping
// addresses, plus a sequencer that reloads the default weight pattern.
module weight_bank
    import weight_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LANES  = DEFAULT_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         Init,
    input  logic                         Req,
    input  logic                         WE,
    input  logic [ADDR_W-1:0]            Address,
    input  logic [LANES-1:0][WIDTH-1:0]  D,
    output logic                         Ready,
    output logic                         Busy,
    output logic [LANES-1:0][WIDTH-1:0]  Q,
    output logic                         Q_valid,
    output logic                         Err
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              word_we [DEPTH];
    logic [WIDTH-1:0]  word_wd [DEPTH];
    logic [ADDR_W-1:0] lane_addr [LANES];

    logic              init_busy;
    logic              init_wr;
    logic [ADDR_W-1:0] init_row;
    logic [WIDTH-1:0]  init_data;

    logic init_start;
    logic accept;
    logic addr_ok;
    logic rd_acc;
    logic wr_acc;

    weight_init_seq #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .start   (init_start),
        .busy    (init_busy),
        .row     (init_row),
        .data    (init_data),
        .wr_en   (init_wr)
    );

    assign Busy  = init_busy;
    assign Ready = !init_busy;

    // Init wins over a coincident request, which is simply dropped.
    assign init_start = Init & Ready;
    assign accept     = Req & Ready & ~Init;
    assign addr_ok    = ({1'b0, Address} < (ADDR_W + 1)'(DEPTH));
    assign rd_acc     = accept & addr_ok & ~WE;
    assign wr_acc     = accept & addr_ok & WE;

    // Per-lane word address, wrapping past the top of the array.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = ADDR_W'(wrap_add(int'(Address), i, DEPTH));
        end
    end

    // Per-word write decode: the init row or any burst lane landing on this word.
    always_comb begin
        for (int w = 0; w < DEPTH; w++) begin
            word_we[w] = 1'b0;
            word_wd[w] = '0;
            if (init_wr && (init_row == ADDR_W'(w))) begin
                word_we[w] = 1'b1;
                word_wd[w] = init_data;
            end
            for (int i = 0; i < LANES; i++) begin
                if (wr_acc && (lane_addr[i] == ADDR_W'(w))) begin
                    word_we[w] = 1'b1;
                    word_wd[w] = D[i];
                end
            end
        end
    end

    // Storage array; contents are only defined once an init pass completes.
    always_ff @(posedge Clock) begin
        for (int w = 0; w < DEPTH; w++) begin
            if (word_we[w]) begin
                mem[w] <= word_wd[w];
            end
        end
    end

    // Registered read data and status pulses; Q holds between reads.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Q       <= '0;
            Q_valid <= 1'b0;
            Err     <= 1'b0;
        end else begin
            Q_valid <= rd_acc;
            Err     <= accept & ~addr_ok;
            if (rd_acc) begin
                for (int i = 0; i < LANES; i++) begin
                    Q[i] <= mem[lane_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
// Self-checking bench for weight_bank: directed steps plus random bursts
// against a behavioural memory model, and a second small-geometry instance.
module tb_weight_bank;

    localparam int WIDTH  = 10;
    localparam int DEPTH  = 30;
    localparam int LANES  = 10;
    localparam int ADDR_W = 5;

    localparam int BW = 8;
    localparam int BD = 16;
    localparam int BL = 4;
    localparam int BA = 4;

    logic Clock = 1'b0;
    logic Reset_n;

    logic                        Init, Req, WE;
    logic [ADDR_W-1:0]           Address;
    logic [LANES-1:0][WIDTH-1:0] D;
    logic                        Ready, Busy, Q_valid, Err;
    logic [LANES-1:0][WIDTH-1:0] Q;

    logic                  bInit, bReq, bWe;
    logic [BA-1:0]         bAddr;
    logic [BL-1:0][BW-1:0] bD;
    logic                  bReady, bBusy, bQvalid, bErr;
    logic [BL-1:0][BW-1:0] bQ;

    int checks = 0;
    int errors = 0;

    logic [63:0] refMem [DEPTH];
    logic [63:0] expQ [LANES];
    logic        expQvalid;
    logic        expErr;

    always #5 Clock = ~Clock;

    weight_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Init(Init), .Req(Req), .WE(WE),
        .Address(Address), .D(D), .Ready(Ready), .Busy(Busy), .Q(Q),
        .Q_valid(Q_valid), .Err(Err)
    );

    weight_bank #(.WIDTH(BW), .DEPTH(BD), .LANES(BL), .ADDR_W(BA)) dutSmall (
        .Clock(Clock), .Reset_n(Reset_n), .Init(bInit), .Req(bReq), .WE(bWe),
        .Address(bAddr), .D(bD), .Ready(bReady), .Busy(bBusy), .Q(bQ),
        .Q_valid(bQvalid), .Err(bErr)
    );

    // Default word built MSB first from the group/parity rules.
    function automatic logic [63:0] refPattern(input int r, input int w, input int l);
        logic [63:0] v;
        int          g;
        int          hi;
        logic        bitv;
        v = '0;
        g = (r / l) % 3;
        if (g == 2) begin
            hi = (w + 1) / 2;
            v  = ((64'd1 << hi) - 64'd1) << (w - hi);
        end else begin
            bitv = (g == 0) && ((r % 2) == 0);
            for (int k = 0; k < w; k++) begin
                v    = {v[62:0], bitv};
                bitv = ~bitv;
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic loadModel();
        for (int r = 0; r < DEPTH; r++) refMem[r] = refPattern(r, WIDTH, LANES);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 64'(Q_valid), 64'(expQvalid));
        checkOutput({tag, ".err"}, 64'(Err), 64'(expErr));
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("%s.q%0d", tag, i), 64'(Q[i]), expQ[i]);
    endtask

    // Drive one cycle of inputs, update the model for that edge, then land on the next negedge.
    task automatic applyStimulus(input logic init, input logic req, input logic we,
                                 input int addr, input logic [LANES-1:0][WIDTH-1:0] data);
        Init    = init;
        Req     = req;
        WE      = we;
        Address = ADDR_W'(addr);
        D       = data;
        expQvalid = 1'b0;
        expErr    = 1'b0;
        if (init) begin
            loadModel();
        end else if (req) begin
            if (addr >= DEPTH) expErr = 1'b1;
            else if (we) for (int i = 0; i < LANES; i++) refMem[(addr + i) % DEPTH] = 64'(data[i]);
            else begin
                expQvalid = 1'b1;
                for (int i = 0; i < LANES; i++) expQ[i] = refMem[(addr + i) % DEPTH];
            end
        end
        @(negedge Clock);
        Init = 1'b0;
        Req  = 1'b0;
        WE   = 1'b0;
    endtask

    task automatic waitReady(input string tag, input int expected);
        int n;
        n = 0;
        while (Ready !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        checkOutput(tag, 64'(n), 64'(expected));
        checkOutput({tag, ".busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        logic [LANES-1:0][WIDTH-1:0] dat;
        int na;
        int nb;

        Reset_n = 1'b0;
        Init = 1'b0; Req = 1'b0; WE = 1'b0; Address = '0; D = '0;
        bInit = 1'b0; bReq = 1'b0; bWe = 1'b0; bAddr = '0; bD = '0;
        expQvalid = 1'b0;
        expErr    = 1'b0;
        for (int i = 0; i < LANES; i++) expQ[i] = '0;

        repeat (2) @(negedge Clock);
        checkAll("reset");
        checkOutput("reset.busy", 64'(Busy), 64'd1);
        checkOutput("reset.ready", 64'(Ready), 64'd0);

        Reset_n = 1'b1;
        loadModel();
        waitReady("init.len", 30);

        applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
        checkAll("rd0");
        checkOutput("rd0.w0", 64'(Q[0]), 64'b1010101010);
        checkOutput("rd0.w1", 64'(Q[1]), 64'b0101010101);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, '0);
        checkAll("rd0.pulse");

        applyStimulus(1'b0, 1'b1, 1'b0, 20, '0);
        checkAll("rd20");
        checkOutput("rd20.w9", 64'(Q[9]), 64'b1111100000);
        applyStimulus(1'b0, 1'b1, 1'b0, 10, '0);
        checkAll("rd10");
        checkOutput("rd10.w4", 64'(Q[4]), 64'b0101010101);

        for (int i = 0; i < LANES; i++) dat[i] = WIDTH'(i + 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 25, dat);
        checkAll("wr25");
        applyStimulus(1'b0, 1'b1, 1'b0, 25, '0);
        checkAll("rd25");
        checkOutput("rd25.w0", 64'(Q[0]), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
        checkAll("rd0wrap");
        checkOutput("rd0wrap.w0", 64'(Q[0]), 64'd6);

        applyStimulus(1'b0, 1'b1, 1'b0, 31, '0);
        checkAll("err.rd");
        applyStimulus(1'b0, 1'b0, 1'b0, 0, '0);
        checkAll("err.clear");
        for (int i = 0; i < LANES; i++) dat[i] = WIDTH'($urandom_range(0, 1023));
        applyStimulus(1'b0, 1'b1, 1'b1, 31, dat);
        checkAll("err.wr");
        applyStimulus(1'b0, 1'b1, 1'b0, 25, '0);
        checkAll("err.after");

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, k * 7, '0);
            checkAll($sformatf("b2b%0d", k));
        end

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < LANES; i++) dat[i] = WIDTH'($urandom_range(0, 1023));
            applyStimulus(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 31), dat);
            checkAll("rnd");
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 25, '0);
        checkAll("pre.init");
        applyStimulus(1'b1, 1'b1, 1'b0, 3, '0);
        checkAll("initreq");
        checkOutput("initreq.busy", 64'(Busy), 64'd1);
        waitReady("reinit.len", 30);
        applyStimulus(1'b0, 1'b1, 1'b0, 25, '0);
        checkAll("reinit.rd25");

        applyStimulus(1'b1, 1'b0, 1'b0, 0, '0);
        repeat (12) @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        expQvalid = 1'b0;
        expErr    = 1'b0;
        for (int i = 0; i < LANES; i++) expQ[i] = '0;
        checkAll("rstmid");
        checkOutput("rstmid.busy", 64'(Busy), 64'd1);
        @(negedge Clock);
        Reset_n = 1'b1;
        waitReady("rstmid.len", 30);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
        checkAll("rstmid.rd0");

        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        na = 0;
        nb = 0;
        for (int n = 1; n <= 200 && (na == 0 || nb == 0); n++) begin
            @(negedge Clock);
            if (bReady === 1'b1 && nb == 0) nb = n;
            if (Ready === 1'b1 && na == 0) na = n;
        end
        checkOutput("small.len", 64'(nb), 64'd16);
        checkOutput("big.len", 64'(na), 64'd30);

        bReq  = 1'b1;
        bAddr = BA'(8);
        @(negedge Clock);
        bReq  = 1'b0;
        checkOutput("small.rd8.valid", 64'(bQvalid), 64'd1);
        for (int i = 0; i < BL; i++)
            checkOutput($sformatf("small.rd8.q%0d", i), 64'(bQ[i]), 64'b11110000);

        bReq  = 1'b1;
        bAddr = BA'(14);
        @(negedge Clock);
        bReq  = 1'b0;
        checkOutput("small.rd14.valid", 64'(bQvalid), 64'd1);
        checkOutput("small.rd14.q2", 64'(bQ[2]), 64'b10101010);
        for (int i = 0; i < BL; i++)
            checkOutput($sformatf("small.rd14.q%0d", i), 64'(bQ[i]), refPattern((14 + i) % BD, BW, BL));
        checkOutput("small.err", 64'(bErr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
